// File: rtl/clock_divider_if.sv
// ============================================================================
// Module      : clock_divider_if
// Description : Divided-clock output bundle (clk/2, clk/4, clk/8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface clock_divider_if;
    logic clk_div2;
    logic clk_div4;
    logic clk_div8;

    modport master (
        output clk_div2,
        output clk_div4,
        output clk_div8
    );

    modport slave (
        input clk_div2,
        input clk_div4,
        input clk_div8
    );
endinterface

`default_nettype wire

// File: rtl/clock_divider.sv
// ============================================================================
// Module      : clock_divider
// Description : Fixed /2, /4, /8 divider built from a 3-bit free-running counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_divider (
    input  wire logic        clk,
    input  wire logic        rst,
    clock_divider_if.master  o_div
);

    localparam logic [2:0] c_CNT_RST = 3'd0;
    localparam logic [2:0] c_CNT_INC = 3'd1;

    logic [2:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= c_CNT_RST;
        end else begin
            r_cnt <= r_cnt + c_CNT_INC;
        end
    end

    // Each counter bit is its own flop, so the ports see pure register outputs
    // that stay phase-aligned and all fall together at the 7->0 wrap.
    assign o_div.clk_div2 = r_cnt[0];
    assign o_div.clk_div4 = r_cnt[1];
    assign o_div.clk_div8 = r_cnt[2];

endmodule

`default_nettype wire

// File: tb/tb_clock_divider.sv
// Testbench for clock_divider: power-up timing, periods/duty, directed vector table,
// and a continuous increment / stability checker.
`default_nettype none

module tb_clock_divider;

    typedef struct {
        logic       rst;
        logic [2:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    clock_divider_if u_if ();

    clock_divider dut (
        .clk   (clk),
        .rst   (rst),
        .o_div (u_if)
    );

    always #10 clk = ~clk;

    logic [2:0] w_out;
    assign w_out = {u_if.clk_div8, u_if.clk_div4, u_if.clk_div2};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, req, $time);
        end
    endtask

    // Continuous checker: +1 mod 8 on every unreset edge, 000 on reset edges,
    // and no change between rising edges.
    logic       mon_en = 1'b0;
    logic [2:0] prev   = 3'b000;
    logic       rst_at_edge;

    always @(posedge clk) begin
        rst_at_edge = rst;
        #1;
        if (mon_en) begin
            if (rst_at_edge) chk("mon_reset", w_out, 3'b000);
            else             chk("mon_incr", w_out, prev + 3'd1);
        end
        prev = w_out;
    end

    always @(negedge clk) begin
        if (mon_en) chk("mon_stable", w_out, prev);
    end

    vec_t vecs[$];

    task automatic add(input logic r, input logic [2:0] e);
        vec_t v;
        v.rst = r;
        v.exp = e;
        vecs.push_back(v);
    endtask

    realtime rise2[$], rise4[$], rise8[$];
    int      hi2, hi4, hi8;
    logic [2:0] last;
    logic [2:0] exp_seq;

    initial begin
        // Directed vectors: rst applied at the falling edge, outputs checked after the next rising edge.
        add(1, 3'b000); add(1, 3'b000);
        add(0, 3'b001); add(0, 3'b010); add(0, 3'b011); add(0, 3'b100);
        add(0, 3'b101); add(0, 3'b110); add(0, 3'b111);
        add(1, 3'b000);                       // mid-count reset at 111
        add(0, 3'b001); add(0, 3'b010); add(0, 3'b011);
        add(1, 3'b000); add(1, 3'b000); add(1, 3'b000); add(1, 3'b000); add(1, 3'b000);
        add(0, 3'b001); add(0, 3'b010); add(0, 3'b011); add(0, 3'b100);
        add(0, 3'b101); add(0, 3'b110); add(0, 3'b111);
        add(0, 3'b000);                       // natural wrap
        add(0, 3'b001);
        add(1, 3'b000);                       // reset at 001
        add(0, 3'b001);

        // Power-up: rst high from 0 ns, released at 25 ns.
        rst = 1'b1;
        @(posedge clk); #1;
        chk("pwrup_10ns", w_out, 3'b000);
        #4 mon_en = 1'b1;
        #10 rst = 1'b0;

        hi2 = 0; hi4 = 0; hi8 = 0;
        last = 3'b000;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            exp_seq = 3'(i);
            if (i == 1)      chk("pwrup_30ns", w_out, 3'b001);
            else if (i == 2) chk("pwrup_50ns", w_out, 3'b010);
            else if (i == 4) chk("pwrup_90ns", w_out, 3'b100);
            else if (i == 8) chk("wrap_170ns", w_out, 3'b000);
            else             chk("freerun", w_out, exp_seq);
            if (w_out[0] && !last[0]) rise2.push_back($realtime);
            if (w_out[1] && !last[1]) rise4.push_back($realtime);
            if (w_out[2] && !last[2]) rise8.push_back($realtime);
            hi2 += int'(w_out[0]);
            hi4 += int'(w_out[1]);
            hi8 += int'(w_out[2]);
            last = w_out;
        end

        checks++;
        if (rise2.size() < 2 || (rise2[1] - rise2[0]) != 40.0) begin
            errors++; $display("FAIL period_div2 actual_rises=%0d required=40ns", rise2.size());
        end
        checks++;
        if (rise4.size() < 2 || (rise4[1] - rise4[0]) != 80.0) begin
            errors++; $display("FAIL period_div4 actual_rises=%0d required=80ns", rise4.size());
        end
        checks++;
        if (rise8.size() < 2 || (rise8[1] - rise8[0]) != 160.0) begin
            errors++; $display("FAIL period_div8 actual_rises=%0d required=160ns", rise8.size());
        end
        checks++;
        if (hi2 != 8 || hi4 != 8 || hi8 != 8) begin
            errors++; $display("FAIL duty actual=%0d/%0d/%0d required=8/8/8 of 16", hi2, hi4, hi8);
        end

        // Table-driven vectors.
        foreach (vecs[k]) begin
            @(negedge clk);
            rst = vecs[k].rst;
            @(posedge clk); #1;
            chk($sformatf("vec%0d", k), w_out, vecs[k].exp);
        end

        // A short rst pulse that misses every rising edge must not disturb counting.
        @(negedge clk);
        rst = 1'b0;
        #2 rst = 1'b1;
        #5 rst = 1'b0;
        @(posedge clk); #1;
        chk("glitch_ignored", w_out, 3'b010);
        @(posedge clk); #1;
        chk("glitch_next", w_out, 3'b011);

        @(negedge clk);
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/clock_divider.md
CLOCK_DIVIDER -- requirements
Module: clock_divider

Interface
REQ-001 Parameters: none; all division ratios (2, 4, 8) are fixed.
REQ-002 clk  input  1  system clock; the only clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset; sampled only on rising clk.
REQ-004 clk_div2  output  1  clk divided by 2, 50% duty.
REQ-005 clk_div4  output  1  clk divided by 4, 50% duty.
REQ-006 clk_div8  output  1  clk divided by 8, 50% duty.
REQ-007 The block SHALL have one clock; reset is synchronous and active-high.

Function
REQ-008 The block SHALL contain a 3-bit free-running up-counter cnt[2:0], clocked on rising clk.
REQ-009 cnt SHALL increment by 1 on every rising clk edge while rst=0.
REQ-010 cnt SHALL wrap from 7 to 0 with no stall or extra cycle.
REQ-011 clk_div2 SHALL equal cnt[0], clk_div4 SHALL equal cnt[1], and clk_div8 SHALL equal cnt[2].
REQ-012 Each output SHALL be driven directly by a flip-flop, with no combinational logic between the register and the port, so the outputs are glitch-free.
REQ-013 All output transitions SHALL occur only on rising clk, at clk-to-q delay.
REQ-014 Outputs SHALL be phase-aligned, and every falling edge of a slower output SHALL coincide with a falling edge of each faster output.
REQ-015 At the 7->0 wrap, all three outputs SHALL fall on the same edge.
REQ-016 Period requirements:
  - clk_div2: high 1 clk cycle, low 1 cycle.
  - clk_div4: high 2 cycles, low 2 cycles.
  - clk_div8: high 4 cycles, low 4 cycles.
REQ-017 First rising edges after reset release:
  - clk_div2 SHALL rise on the 1st rising clk with rst=0.
  - clk_div4 SHALL rise on the 2nd.
  - clk_div8 SHALL rise on the 4th.
REQ-018 The block SHALL have no enable, load or other inputs; behaviour is fully determined by clk and rst.
REQ-019 The outputs are data-domain signals; the block SHALL NOT use them to clock its own logic.

Reset
REQ-020 While rst=1 at a rising clk, cnt SHALL load 0, driving all three outputs to 0 after that edge.
REQ-021 Before the first rising clk with rst=1, the outputs SHALL be treated as unknown; there is no asynchronous clear.
REQ-022 A reset asserted mid-count (any cnt value) SHALL clear all outputs to 0 on the next rising clk, regardless of phase.
REQ-023 A reset held for N edges SHALL keep the outputs at 0 for those N edges.
REQ-024 Counting SHALL resume from 0 on the first rising clk with rst=0, and that edge SHALL set cnt=1.
REQ-025 rst pulses shorter than a clk period that miss a rising edge SHALL have no effect.

Verification
REQ-026 Power-up reset, clk period 20 ns:
  - Stimulus: rst=1 from 0 ns, released at 25 ns.
  - At the 10 ns edge: all outputs 0.
  - At 30 ns: div2=1, div4=0, div8=0.
  - At 50 ns: div2=0, div4=1.
  - At 90 ns: div2=0, div4=0, div8=1.
REQ-027 Free run for 500 ns after release:
  - Outputs follow (div8,div4,div2) = 001, 010, 011, 100, 101, 110, 111, 000, ... on successive edges.
  - Measured periods: 40 ns, 80 ns, 160 ns.
  - Each output is high exactly 50% of its period.
REQ-028 Wrap check: at the edge where cnt goes 7->0 (170 ns in REQ-026 timing), all outputs fall from 1 to 0 simultaneously.
REQ-029 Mid-operation reset:
  - Stimulus: assert rst for one edge while outputs are 111.
  - Required: 000 on that edge, then 001 on the next edge.
REQ-030 Held reset:
  - Stimulus: rst=1 for 5 consecutive edges.
  - Required: outputs stay 000 throughout, and the sequence restarts at 001 after release.
REQ-031 Checker, on every rising clk with rst=0:
  - The 3-bit output vector {div8,div4,div2} equals the previous value + 1 mod 8.
  - No output changes between rising clk edges.
